cache_ctrl_dm: RTL and testbench

Parametrised direct-mapped, single-word-line cache controller that owns its own valid/dirty/tag/data arrays. It sits between a CPU request port and a memory port with a req/ack handshake. It keeps the IDLE..RESPONSE state sequence and the `state_out` encoding, and adds real storage, dirty write-back eviction, a write-through mode and hit/miss statistics.

---
 rtl/cache_ctrl_dm.sv | 187 ++++++++++++++++++
 tb/tb_cache_ctrl_dm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, single-word-line cache controller owning valid/dirty/tag/data storage.
// Latency to cpu_done: rd hit 3, wr hit/clean wr miss 4 (WB), rd miss 4+W, dirty rd miss 5+W1+W2.
// Backpressure: one request in flight, cpu_ready only in IDLE; mem_req/addr/data held stable until mem_ack.
module cache_ctrl_dm #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int INDEX_W    = 2,
  parameter int WRITE_BACK = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        state_out,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TAG_CHECK = 4'd1,
    RD_HIT    = 4'd2,
    WR_HIT    = 4'd3,
    EVICT     = 4'd4,
    WR_MISS   = 4'd5,
    RD_MISS   = 4'd6,
    UPDATE    = 4'd7,
    RESPONSE  = 4'd8
  } state_e;

  // Plain 4-bit register so codes outside the enum (e.g. from an upset) are representable and recoverable.
  logic [3:0] state_q, state_d;

  // Request captured in IDLE; the CPU inputs are not looked at again for this transaction.
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  // Line storage: valid/dirty are reset, tag/data are not (valid=0 masks their contents).
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               need_evict;
  logic               hit_inc;
  logic               miss_inc;

  assign idx        = addr_q[INDEX_W-1:0];
  assign tag        = addr_q[ADDR_W-1:INDEX_W];
  assign hit        = valid_q[idx] && (tag_mem[idx] == tag);
  assign need_evict = (WRITE_BACK != 0) && valid_q[idx] && dirty_q[idx];

  assign state_out = state_q;
  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // State register; reset forces IDLE, which also drops mem_req/cpu_done combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and Moore/Mealy outputs; memory requests are driven purely from the current state.
  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_d = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (hit) begin
          hit_inc = 1'b1;
          state_d = we_q ? WR_HIT : RD_HIT;
        end else begin
          miss_inc = 1'b1;
          if (need_evict) state_d = EVICT;
          else            state_d = we_q ? WR_MISS : RD_MISS;
        end
      end
      RD_HIT: state_d = RESPONSE;
      WR_HIT, WR_MISS: begin
        if (WRITE_BACK != 0) begin
          state_d = UPDATE;
        end else begin
          // Write-through: the store reaches memory before the line is updated.
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_ack) state_d = UPDATE;
        end
      end
      EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[idx], idx};
        mem_wdata = data_mem[idx];
        if (mem_ack) state_d = we_q ? WR_MISS : RD_MISS;
      end
      RD_MISS: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = UPDATE;
      end
      UPDATE:   state_d = RESPONSE;
      RESPONSE: begin
        cpu_done = 1'b1;
        state_d  = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Request latch, fill register, read-data register and saturating statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      fill_q     <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (state_q == RD_MISS && mem_ack) fill_q <= mem_rdata;
      if (state_q == RD_HIT)                   rdata_q <= data_mem[idx];
      else if (state_q == UPDATE && !we_q)     rdata_q <= fill_q;
      if (hit_inc && hit_cnt_q != {CNT_W{1'b1}})   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_inc && miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Valid/dirty bookkeeping; a line written in write-through mode is never dirty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= we_q && (WRITE_BACK != 0);
    end
  end

  // Tag/data arrays, written once per transaction in UPDATE with store data or the fill word.
  always_ff @(posedge clk) begin
    if (state_q == UPDATE) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= we_q ? wdata_q : fill_q;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Bench for cache_ctrl_dm: write-back instance (CNT_W=2) and write-through instance share one clock.
// Memory models answer reads with addr^0xA0 after a programmable wait and log writes.
// Expected responses are queued at request time and checked when cpu_done arrives.
module tb_cache_ctrl_dm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- write-back instance (a_) ----------------
  logic       a_rst, a_cpu_req, a_cpu_we, a_cpu_ready, a_cpu_done;
  logic [7:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic       a_mem_req, a_mem_we, a_mem_ack;
  logic [7:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0] a_state;
  logic [1:0] a_hit, a_miss;

  cache_ctrl_dm #(.ADDR_W(8), .DATA_W(8), .INDEX_W(2), .WRITE_BACK(1), .CNT_W(2)) u_a (
    .clk(clk), .rst(a_rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ready(a_cpu_ready), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
    .state_out(a_state), .hit_cnt(a_hit), .miss_cnt(a_miss)
  );

  // ---------------- write-through instance (b_) ----------------
  logic        b_rst, b_cpu_req, b_cpu_we, b_cpu_ready, b_cpu_done;
  logic [7:0]  b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [7:0]  b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_state;
  logic [15:0] b_hit, b_miss;

  cache_ctrl_dm #(.ADDR_W(8), .DATA_W(8), .INDEX_W(2), .WRITE_BACK(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(b_rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ready(b_cpu_ready), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .state_out(b_state), .hit_cnt(b_hit), .miss_cnt(b_miss)
  );

  // ---------------- memory models ----------------
  int         a_w = 0, b_w = 0;
  bit         a_hold = 1'b0;
  int         a_cnt = 0, b_cnt = 0;
  int         a_wr_n = 0, b_wr_n = 0;
  logic [7:0] a_wr_addr = 8'h00, a_wr_data = 8'h00, b_wr_addr = 8'h00, b_wr_data = 8'h00;

  assign a_mem_ack   = a_mem_req && !a_hold && (a_cnt >= a_w);
  assign a_mem_rdata = a_mem_addr ^ 8'hA0;
  assign b_mem_ack   = b_mem_req && (b_cnt >= b_w);
  assign b_mem_rdata = b_mem_addr ^ 8'hA0;

  always @(posedge clk) begin
    if (a_mem_req && a_mem_ack) begin
      a_cnt <= 0;
      if (a_mem_we) begin
        a_wr_n <= a_wr_n + 1; a_wr_addr <= a_mem_addr; a_wr_data <= a_mem_wdata;
      end
    end else if (a_mem_req) a_cnt <= a_cnt + 1;
    else                    a_cnt <= 0;
  end

  always @(posedge clk) begin
    if (b_mem_req && b_mem_ack) begin
      b_cnt <= 0;
      if (b_mem_we) begin
        b_wr_n <= b_wr_n + 1; b_wr_addr <= b_mem_addr; b_wr_data <= b_mem_wdata;
      end
    end else if (b_mem_req) b_cnt <= b_cnt + 1;
    else                    b_cnt <= 0;
  end

  // ---------------- instance select for the shared driver ----------------
  logic       sel = 1'b0;
  wire        s_ready  = sel ? b_cpu_ready : a_cpu_ready;
  wire        s_done   = sel ? b_cpu_done  : a_cpu_done;
  wire  [7:0] s_rdata  = sel ? b_cpu_rdata : a_cpu_rdata;
  wire        s_memreq = sel ? b_mem_req   : a_mem_req;
  wire  [3:0] s_state  = sel ? b_state     : a_state;

  typedef struct { logic [7:0] rd; int lat; bit is_rd; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int ah = 0, am = 0, bh = 0, bm = 0;
  int n_req, n_ev;

  function automatic int sat3(input int x);
    return (x < 3) ? x + 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    if (sel) begin
      b_cpu_req = req; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wd;
    end else begin
      a_cpu_req = req; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wd;
    end
  endtask

  // One CPU transaction: push the expectation, issue, then wait (bounded) for cpu_done.
  task automatic op(input string tag, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                    input logic [7:0] exp_rd, input int exp_lat, output int nreq, output int nev);
    int k, cyc;
    bit done;
    exp_t e;
    k = 0;
    while (!s_ready && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_ready"}, 32'(s_ready), 1);
    exp_q.push_back('{rd: exp_rd, lat: exp_lat, is_rd: !we});
    drive(1'b1, we, addr, wd);
    cyc = 0; done = 1'b0; nreq = 0; nev = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) drive(1'b0, 1'b0, 8'h00, 8'h00);
      if (s_memreq) nreq++;
      if (s_state == 4'd4) nev++;
      if (s_done) done = 1'b1;
    end
    e = exp_q.pop_front();
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    if (e.is_rd) chk({tag, "_rdata"}, 32'(s_rdata), 32'(e.rd));
  endtask

  initial begin
    a_rst = 1'b0; b_rst = 1'b0;
    a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = 8'h00; a_cpu_wdata = 8'h00;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 8'h00; b_cpu_wdata = 8'h00;
    #1;
    chk("rst_state", 32'(a_state), 0);
    chk("rst_ready", 32'(a_cpu_ready), 1);
    chk("rst_memreq", 32'(a_mem_req), 0);
    chk("rst_done", 32'(a_cpu_done), 0);
    chk("rst_rdata", 32'(a_cpu_rdata), 0);
    chk("rst_hit", 32'(a_hit), 0);
    chk("rst_miss", 32'(a_miss), 0);
    chk("rst_b_miss", 32'(b_miss), 0);
    @(negedge clk); @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);

    // Test 1: cold read miss with two wait cycles, then a read hit.
    sel = 1'b0; a_w = 2;
    op("t1_miss", 1'b0, 8'h05, 8'h00, 8'hA5, 6, n_req, n_ev);
    am = sat3(am);
    chk("t1_rdmiss_cycles", 32'(n_req), 3);
    chk("t1_miss_cnt", 32'(a_miss), 32'(am));
    a_w = 0;
    op("t1_hit", 1'b0, 8'h05, 8'h00, 8'hA5, 3, n_req, n_ev);
    ah = sat3(ah);
    chk("t1_hit_memreq", 32'(n_req), 0);
    chk("t1_hit_cnt", 32'(a_hit), 32'(ah));

    // Test 2: write-back write hit stays internal, then read it back.
    op("t2_wr", 1'b1, 8'h05, 8'h3C, 8'h00, 4, n_req, n_ev);
    ah = sat3(ah);
    chk("t2_wr_memreq", 32'(n_req), 0);
    op("t2_rd", 1'b0, 8'h05, 8'h00, 8'h3C, 3, n_req, n_ev);
    ah = sat3(ah);
    chk("t2_hit_cnt", 32'(a_hit), 32'(ah));

    // Test 3: conflicting read evicts the dirty line first.
    op("t3_evict", 1'b0, 8'h45, 8'h00, 8'hE5, 5, n_req, n_ev);
    am = sat3(am);
    chk("t3_evict_cycles", 32'(n_ev), 1);
    chk("t3_memreq_cycles", 32'(n_req), 2);
    chk("t3_wb_addr", 32'(a_wr_addr), 32'h05);
    chk("t3_wb_data", 32'(a_wr_data), 32'h3C);
    chk("t3_wb_count", 32'(a_wr_n), 1);
    chk("t3_miss_cnt", 32'(a_miss), 32'(am));

    // Test 4: write-through instance.
    sel = 1'b1;
    op("t4_wrmiss", 1'b1, 8'h02, 8'h77, 8'h00, 4, n_req, n_ev);
    bm++;
    chk("t4_wr_memreq", 32'(n_req), 1);
    chk("t4_wr_addr", 32'(b_wr_addr), 32'h02);
    chk("t4_wr_data", 32'(b_wr_data), 32'h77);
    chk("t4_evict", 32'(n_ev), 0);
    op("t4_rdmiss", 1'b0, 8'h42, 8'h00, 8'hE2, 4, n_req, n_ev);
    bm++;
    chk("t4_rd_evict", 32'(n_ev), 0);
    chk("t4_wr_count", 32'(b_wr_n), 1);
    op("t4_wrhit", 1'b1, 8'h42, 8'h99, 8'h00, 4, n_req, n_ev);
    bh++;
    chk("t4_wrhit_addr", 32'(b_wr_addr), 32'h42);
    chk("t4_wrhit_data", 32'(b_wr_data), 32'h99);
    op("t4_rdhit", 1'b0, 8'h42, 8'h00, 8'h99, 3, n_req, n_ev);
    bh++;
    chk("t4_hit_cnt", 32'(b_hit), 32'(bh));
    chk("t4_miss_cnt", 32'(b_miss), 32'(bm));

    // Test 5: asynchronous reset in the middle of a stalled read miss.
    sel = 1'b0; a_hold = 1'b1;
    begin
      int k;
      k = 0;
      while (!a_cpu_ready && k < 50) begin @(negedge clk); k++; end
      drive(1'b1, 1'b0, 8'h85, 8'h00);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      k = 0;
      while (a_state != 4'd6 && k < 20) begin @(negedge clk); k++; end
    end
    chk("t5_in_rdmiss", 32'(a_state), 6);
    chk("t5_memreq_before", 32'(a_mem_req), 1);
    #2 a_rst = 1'b0;
    #1;
    chk("t5_async_state", 32'(a_state), 0);
    chk("t5_async_memreq", 32'(a_mem_req), 0);
    chk("t5_async_hit", 32'(a_hit), 0);
    chk("t5_async_miss", 32'(a_miss), 0);
    @(negedge clk); @(negedge clk);
    a_rst = 1'b1; a_hold = 1'b0;
    ah = 0; am = 0;
    @(negedge clk);
    op("t5_refetch", 1'b0, 8'h45, 8'h00, 8'hE5, 4, n_req, n_ev);
    am = sat3(am);
    chk("t5_refetch_miss", 32'(a_miss), 32'(am));

    // Test 6: hit counter saturates at 3 with CNT_W=2; illegal state recovers.
    for (int i = 0; i < 5; i++) begin
      op("t6_hit", 1'b0, 8'h45, 8'h00, 8'hE5, 3, n_req, n_ev);
      ah = sat3(ah);
    end
    chk("t6_hit_sat", 32'(a_hit), 32'(ah));
    chk("t6_miss_kept", 32'(a_miss), 32'(am));
    @(negedge clk);
    force u_a.state_q = 4'hC;
    #1;
    chk("t6_forced", 32'(a_state), 32'hC);
    release u_a.state_q;
    @(posedge clk);
    #1;
    chk("t6_recover", 32'(a_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
